// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: drives the PC onto the address bus, runs a req/ack
// memory read and holds the fetched word in a valid/ready instruction register.
module fetch_unit #(
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned DATA_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_en,
    input  logic                 flush,
    output logic                 pc_oe,
    output logic                 pc_inc,
    input  logic [ADDR_SIZE-1:0] addr_bus,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic                 mem_ack,
    input  logic [DATA_SIZE-1:0] mem_data,
    output logic [DATA_SIZE-1:0] ir,
    output logic [ADDR_SIZE-1:0] ir_addr,
    output logic                 ir_valid,
    input  logic                 ir_ready,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        MEM   = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic [ADDR_SIZE-1:0]   ir_addr_q, ir_addr_d;
    logic [DATA_SIZE-1:0]   ir_q, ir_d;
    logic                   ir_valid_q, ir_valid_d;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            ir_addr_q  <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            ir_addr_q  <= ir_addr_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    // Next-state and strobe decode; strobes depend on state only (flush gates pc_inc)
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        ir_addr_d  = ir_addr_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        pc_oe      = 1'b0;
        pc_inc     = 1'b0;
        mem_rd     = 1'b0;

        case (state_q)
            IDLE: begin
                if (fetch_en && !flush) state_d = ADDR;
            end
            ADDR: begin
                pc_oe  = 1'b1;
                pc_inc = !flush;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    mem_addr_d = addr_bus;
                    state_d    = MEM;
                end
            end
            MEM: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    if (!flush) begin
                        ir_d       = mem_data;
                        ir_addr_d  = mem_addr_q;
                        ir_valid_d = 1'b1;
                        state_d    = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (flush) begin
                    // A request is never withdrawn; wait out the ack and drop the data
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                mem_rd = 1'b1;
                if (mem_ack) state_d = IDLE;
            end
            HOLD: begin
                if (flush) begin
                    ir_valid_d = 1'b0;
                    state_d    = IDLE;
                end else if (ir_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = fetch_en ? ADDR : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign mem_addr = mem_addr_q;
    assign ir       = ir_q;
    assign ir_addr  = ir_addr_q;
    assign ir_valid = ir_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table plus hand-written multi-cycle
// sequences, with a small PC register model driving the address bus.
module tb_fetch_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_en, flush, ir_ready, mem_ack;
    logic [DW-1:0] mem_data;
    logic          pc_oe, pc_inc, mem_rd, busy, ir_valid;
    logic [AW-1:0] addr_bus, mem_addr, ir_addr;
    logic [DW-1:0] ir;

    logic          pc_ld;
    logic [AW-1:0] pc_ld_val, pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // PC register model: load wins over post-increment
    always @(posedge clk) begin
        if (pc_ld)       pc <= pc_ld_val;
        else if (pc_inc) pc <= pc + 32'd1;
    end

    assign addr_bus = pc_oe ? pc : 32'hDEAD_BEEF;

    fetch_unit #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_en (fetch_en),
        .flush    (flush),
        .pc_oe    (pc_oe),
        .pc_inc   (pc_inc),
        .addr_bus (addr_bus),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .ir       (ir),
        .ir_addr  (ir_addr),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .busy     (busy)
    );

    typedef struct {
        logic          fe, fl, rdy, ack, ld;
        logic [DW-1:0] data;
        logic [AW-1:0] ld_val;
        logic [4:0]    exp_strb;   // {pc_oe, pc_inc, mem_rd, busy, ir_valid}
        logic [DW-1:0] exp_ir;
        logic [AW-1:0] exp_ir_addr, exp_mem_addr, exp_pc;
    } vec_t;

    function automatic vec_t mk(input logic fe, fl, rdy, ack, input logic [DW-1:0] data,
                                input logic ld, input logic [AW-1:0] ld_val,
                                input logic [4:0] strb, input logic [DW-1:0] eir,
                                input logic [AW-1:0] eira, ema, epc);
        vec_t v;
        v.fe = fe; v.fl = fl; v.rdy = rdy; v.ack = ack; v.data = data;
        v.ld = ld; v.ld_val = ld_val;
        v.exp_strb = strb; v.exp_ir = eir; v.exp_ir_addr = eira;
        v.exp_mem_addr = ema; v.exp_pc = epc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply inputs for the coming edge at the falling edge, then settle
    task automatic drive(input logic fe, fl, rdy, ack, input logic [DW-1:0] data,
                         input logic ld, input logic [AW-1:0] ld_val);
        @(negedge clk);
        fetch_en = fe; flush = fl; ir_ready = rdy; mem_ack = ack; mem_data = data;
        pc_ld = ld; pc_ld_val = ld_val;
        #1;
    endtask

    task automatic expect_all(input string nm, input logic [4:0] strb,
                              input logic [DW-1:0] eir, input logic [AW-1:0] eira,
                              input logic [AW-1:0] ema, input logic [AW-1:0] epc);
        chk({nm, " strobes"}, 32'({pc_oe, pc_inc, mem_rd, busy, ir_valid}), 32'(strb));
        chk({nm, " ir"}, 32'(ir), 32'(eir));
        chk({nm, " ir_addr"}, 32'(ir_addr), 32'(eira));
        chk({nm, " mem_addr"}, 32'(mem_addr), 32'(ema));
        chk({nm, " pc"}, 32'(pc), 32'(epc));
    endtask

    vec_t vecs[16];

    initial begin
        // Back-to-back fetch from 0x100, flush in ADDR with PC load, flush in HOLD
        vecs[0]  = mk(1,0,0,0, 32'h0,        0, 32'h0,   5'b00000, 32'h0,        32'h0,   32'h0,   32'h100);
        vecs[1]  = mk(0,0,0,0, 32'h0,        0, 32'h0,   5'b11010, 32'h0,        32'h0,   32'h0,   32'h100);
        vecs[2]  = mk(0,0,0,1, 32'hA0000001, 0, 32'h0,   5'b00110, 32'h0,        32'h0,   32'h100, 32'h101);
        vecs[3]  = mk(1,0,1,0, 32'h0,        0, 32'h0,   5'b00011, 32'hA0000001, 32'h100, 32'h100, 32'h101);
        vecs[4]  = mk(0,0,0,0, 32'h0,        0, 32'h0,   5'b11010, 32'hA0000001, 32'h100, 32'h100, 32'h101);
        vecs[5]  = mk(0,0,0,1, 32'hA0000002, 0, 32'h0,   5'b00110, 32'hA0000001, 32'h100, 32'h101, 32'h102);
        vecs[6]  = mk(0,0,1,0, 32'h0,        0, 32'h0,   5'b00011, 32'hA0000002, 32'h101, 32'h101, 32'h102);
        vecs[7]  = mk(1,0,0,0, 32'h0,        0, 32'h0,   5'b00000, 32'hA0000002, 32'h101, 32'h101, 32'h102);
        vecs[8]  = mk(0,1,0,0, 32'h0,        1, 32'h200, 5'b10010, 32'hA0000002, 32'h101, 32'h101, 32'h102);
        vecs[9]  = mk(1,0,0,0, 32'h0,        0, 32'h0,   5'b00000, 32'hA0000002, 32'h101, 32'h101, 32'h200);
        vecs[10] = mk(0,0,0,0, 32'h0,        0, 32'h0,   5'b11010, 32'hA0000002, 32'h101, 32'h101, 32'h200);
        vecs[11] = mk(0,0,0,1, 32'hB0000200, 0, 32'h0,   5'b00110, 32'hA0000002, 32'h101, 32'h200, 32'h201);
        vecs[12] = mk(1,1,1,0, 32'h0,        0, 32'h0,   5'b00011, 32'hB0000200, 32'h200, 32'h200, 32'h201);
        vecs[13] = mk(0,0,0,1, 32'h5555AAAA, 0, 32'h0,   5'b00000, 32'hB0000200, 32'h200, 32'h200, 32'h201);
        vecs[14] = mk(1,1,0,0, 32'h0,        0, 32'h0,   5'b00000, 32'hB0000200, 32'h200, 32'h200, 32'h201);
        vecs[15] = mk(0,0,0,0, 32'h0,        0, 32'h0,   5'b00000, 32'hB0000200, 32'h200, 32'h200, 32'h201);

        rst = 1'b1;
        fetch_en = 0; flush = 0; ir_ready = 0; mem_ack = 0; mem_data = '0;
        pc_ld = 1'b1; pc_ld_val = 32'h100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_all("reset", 5'b00000, 32'h0, 32'h0, 32'h0, 32'h100);
        rst = 1'b0;
        pc_ld = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].fe, vecs[i].fl, vecs[i].rdy, vecs[i].ack, vecs[i].data,
                  vecs[i].ld, vecs[i].ld_val);
            expect_all($sformatf("row%0d", i), vecs[i].exp_strb, vecs[i].exp_ir,
                       vecs[i].exp_ir_addr, vecs[i].exp_mem_addr, vecs[i].exp_pc);
        end

        // Ack arrives on the fifth MEM cycle; non-ack data must not be captured
        drive(1,0,0,0, 32'h0, 0, 32'h0);
        expect_all("slow idle", 5'b00000, 32'hB0000200, 32'h200, 32'h200, 32'h201);
        drive(0,0,0,0, 32'h0, 0, 32'h0);
        expect_all("slow addr", 5'b11010, 32'hB0000200, 32'h200, 32'h200, 32'h201);
        for (int i = 0; i < 5; i++) begin
            drive(0,0,0, (i == 4), (i == 4) ? 32'hC0000201 : 32'hBAD00000 + 32'(i), 0, 32'h0);
            expect_all($sformatf("slow mem%0d", i), 5'b00110, 32'hB0000200, 32'h200,
                       32'h201, 32'h202);
        end

        // Decoder stalls for 6 cycles; acks and fetch_en are ignored in HOLD
        for (int i = 0; i < 6; i++) begin
            drive(1,0,0,1, 32'h12345678, 0, 32'h0);
            expect_all($sformatf("stall%0d", i), 5'b00011, 32'hC0000201, 32'h201,
                       32'h201, 32'h202);
        end
        drive(1,0,1,0, 32'h0, 0, 32'h0);
        expect_all("accept", 5'b00011, 32'hC0000201, 32'h201, 32'h201, 32'h202);
        drive(0,0,0,0, 32'h0, 0, 32'h0);
        expect_all("resume addr", 5'b11010, 32'hC0000201, 32'h201, 32'h201, 32'h202);

        // Flush in MEM with ack three cycles later: drain, discard, reload PC
        drive(0,1,0,0, 32'h0, 1, 32'h300);
        expect_all("flush mem", 5'b00110, 32'hC0000201, 32'h201, 32'h202, 32'h203);
        for (int i = 0; i < 3; i++) begin
            drive(0, (i == 0), 0, (i == 2), 32'hEEEE0000 + 32'(i), 0, 32'h0);
            expect_all($sformatf("drain%0d", i), 5'b00110, 32'hC0000201, 32'h201,
                       32'h202, 32'h300);
        end
        drive(1,0,0,0, 32'h0, 0, 32'h0);
        expect_all("post drain", 5'b00000, 32'hC0000201, 32'h201, 32'h202, 32'h300);
        drive(0,0,0,0, 32'h0, 0, 32'h0);
        expect_all("new pc addr", 5'b11010, 32'hC0000201, 32'h201, 32'h202, 32'h300);
        drive(0,0,0,0, 32'h0, 0, 32'h0);
        expect_all("new pc mem", 5'b00110, 32'hC0000201, 32'h201, 32'h300, 32'h301);

        // Reset while the read is outstanding, then a late ack
        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_all("rst in mem", 5'b00000, 32'h0, 32'h0, 32'h0, 32'h301);
        @(negedge clk);
        rst = 1'b0;
        drive(0,0,1,1, 32'hF00DF00D, 0, 32'h0);
        expect_all("late ack", 5'b00000, 32'h0, 32'h0, 32'h0, 32'h301);
        drive(0,0,0,0, 32'h0, 0, 32'h0);
        expect_all("after late ack", 5'b00000, 32'h0, 32'h0, 32'h0, 32'h301);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
